gates_exerciser: RTL and testbench

- Sequential driver/checker for the 3-input basic-gate unit (t0 = a AND b, t1 = a OR b, t2 = NOT c).
- On a start pulse, it drives all 8 {a,b,c} combinations onto the unit, holds each for HOLD cycles, and samples t0/t1/t2 once per vector.
- It compares the samples against expected values, counts mismatches and reports pass/fail with a done pulse.
- It replaces hand-written delay stimulus with a reusable, self-checking block for hardware and bench use.

---
 rtl/gates_exerciser.sv | 155 +++++++++++++++
 tb/tb_gates_exerciser.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gates_exerciser.sv
// gates_exerciser
//   Self-checking stimulus engine for a 3-input basic-gate unit
//   (t0 = a AND b, t1 = a OR b, t2 = NOT c). A start pulse walks {a,b,c}
//   through all eight combinations, holding each one for HOLD cycles. The
//   responses are sampled on the last hold cycle of each vector. The block
//   counts mismatching vectors and reports the result with a one-cycle done
//   pulse.
//
// Parameters
//   HOLD  cycles each vector is held (>= 2)
//   ERRW  width of the saturating mismatch counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a run (only honoured while idle)
//   a, b, c    stimulus to the gate unit ({a,b,c} == vec_idx, a is the MSB)
//   t0, t1, t2 responses from the gate unit
//   busy       high while vectors are being driven
//   done       one-cycle pulse at the end of a run
//   pass       last completed run had zero mismatches
//   err_count  mismatching vectors in the current/last run (saturating)
//   fail_vec   index of the first mismatching vector
//   vec_idx    index of the vector currently driven
module gates_exerciser #(
  parameter int HOLD = 20,
  parameter int ERRW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            a,
  output logic            b,
  output logic            c,
  input  logic            t0,
  input  logic            t1,
  input  logic            t2,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [2:0]      fail_vec,
  output logic [2:0]      vec_idx
);

  localparam int HW = $clog2(HOLD);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [ERRW-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [HW-1:0]   r_hold;
  logic [2:0]      r_vec_idx;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [ERRW-1:0] r_err;
  logic [2:0]      r_fail_vec;

  logic            w_sample;
  logic            w_mismatch;
  logic [ERRW-1:0] w_err_next;

  // The stimulus pins are the vector index itself; it is held at 0 outside
  // DRIVE, so a/b/c idle low without extra registers.
  assign a = r_vec_idx[2];
  assign b = r_vec_idx[1];
  assign c = r_vec_idx[0];

  // Last hold cycle of the current vector: the unit has had at least one
  // full cycle to settle on the registered stimulus.
  assign w_sample   = (r_state == S_DRIVE) && (r_hold == HOLD_LAST);
  assign w_mismatch = (t0 != (a & b)) || (t1 != (a | b)) || (t2 != ~c);

  // Error count after this cycle's sample, saturating at all-ones.
  always_comb begin
    w_err_next = r_err;
    if (w_sample && w_mismatch && (r_err != ERR_MAX)) begin
      w_err_next = r_err + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_vec_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_fail_vec <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= S_DRIVE;
            r_hold     <= '0;
            r_vec_idx  <= '0;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_fail_vec <= '0;
          end
        end

        S_DRIVE: begin
          if (w_sample) begin
            r_err  <= w_err_next;
            r_hold <= '0;
            // Only the first failing vector of a run is recorded.
            if (w_mismatch && (r_err == '0)) begin
              r_fail_vec <= r_vec_idx;
            end
            if (r_vec_idx == 3'd7) begin
              r_state   <= S_DONE;
              r_vec_idx <= '0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_pass    <= (w_err_next == '0);
            end else begin
              r_vec_idx <= r_vec_idx + 3'd1;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        S_DONE: begin
          // start is deliberately ignored here; it is not queued.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail_vec;
  assign vec_idx   = r_vec_idx;

endmodule

// File: tb/tb_gates_exerciser.sv
module tb_gates_exerciser;

  // Three instances: 0 -> HOLD=4/ERRW=4, 1 -> HOLD=2/ERRW=4, 2 -> HOLD=2/ERRW=2
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rs [3];
  logic       st [3];
  logic [1:0] md [3];   // response model: 0 good, 1 t2 stuck 0, 2 t0/t1 swapped, 3 inverted
  logic       ao [3];
  logic       bo [3];
  logic       co [3];
  logic       t0 [3];
  logic       t1 [3];
  logic       t2 [3];
  logic       bz [3];
  logic       dn [3];
  logic       ps [3];
  logic [2:0] fv [3];
  logic [2:0] vi [3];
  logic [3:0] ev [3];
  logic [3:0] err0;
  logic [3:0] err1;
  logic [1:0] err2;

  int checks = 0;
  int errors = 0;

  gates_exerciser #(.HOLD(4), .ERRW(4)) u_h4 (
    .clk(clk), .rst(rs[0]), .start(st[0]), .a(ao[0]), .b(bo[0]), .c(co[0]),
    .t0(t0[0]), .t1(t1[0]), .t2(t2[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .err_count(err0), .fail_vec(fv[0]), .vec_idx(vi[0]));

  gates_exerciser #(.HOLD(2), .ERRW(4)) u_h2 (
    .clk(clk), .rst(rs[1]), .start(st[1]), .a(ao[1]), .b(bo[1]), .c(co[1]),
    .t0(t0[1]), .t1(t1[1]), .t2(t2[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .err_count(err1), .fail_vec(fv[1]), .vec_idx(vi[1]));

  gates_exerciser #(.HOLD(2), .ERRW(2)) u_e2 (
    .clk(clk), .rst(rs[2]), .start(st[2]), .a(ao[2]), .b(bo[2]), .c(co[2]),
    .t0(t0[2]), .t1(t1[2]), .t2(t2[2]), .busy(bz[2]), .done(dn[2]), .pass(ps[2]),
    .err_count(err2), .fail_vec(fv[2]), .vec_idx(vi[2]));

  function automatic logic [2:0] resp(input logic [1:0] m, input logic x, input logic y,
                                      input logic z);
    logic [2:0] good;
    good = {x & y, x | y, ~z};
    case (m)
      2'd1:    resp = {good[2:1], 1'b0};
      2'd2:    resp = {good[1], good[2], good[0]};
      2'd3:    resp = ~good;
      default: resp = good;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      {t0[k], t1[k], t2[k]} = resp(md[k], ao[k], bo[k], co[k]);
    end
    ev[0] = err0;
    ev[1] = err1;
    ev[2] = {2'b00, err2};
  end

  function automatic int hold_of(input int k);
    hold_of = (k == 0) ? 4 : 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start, follow the whole run and check the result.
  task automatic run_check(input string name, input int k, input int exp_err,
                           input int exp_fv, input int exp_pass);
    int h;
    int n;
    int bad_n;
    int bad_v;
    h = hold_of(k);
    st[k] = 1'b1;
    step();
    st[k] = 1'b0;
    chk({name, ".busy_first"}, int'(bz[k]), 1);
    n = 0;
    bad_n = -1;
    bad_v = 0;
    while (!dn[k] && n < 200) begin
      if (bad_n < 0 && ({ao[k], bo[k], co[k]} != 3'(n / h) || !bz[k] || vi[k] != 3'(n / h))) begin
        bad_n = n;
        bad_v = int'({bz[k], ao[k], bo[k], co[k]});
      end
      step();
      n++;
    end
    chk({name, ".latency"}, n, 8 * h);
    if (bad_n >= 0) chk({name, ".stim_cycle"}, bad_v, 8 + (bad_n / h));
    chk({name, ".done_busy"}, int'(bz[k]), 0);
    chk({name, ".done_abc"}, int'({ao[k], bo[k], co[k], vi[k]}), 0);
    chk({name, ".err_count"}, int'(ev[k]), exp_err);
    if (exp_err != 0) chk({name, ".fail_vec"}, int'(fv[k]), exp_fv);
    chk({name, ".pass"}, int'(ps[k]), exp_pass);
    step();
    chk({name, ".done_pulse_end"}, int'(dn[k]), 0);
    chk({name, ".pass_hold"}, int'(ps[k]), exp_pass);
    $display("run %s: inst=%0d mode=%0d cycles=%0d err=%0d fail_vec=%0d pass=%0d",
             name, k, md[k], n, ev[k], fv[k], ps[k]);
  endtask

  typedef struct {
    string name;
    int    inst;
    int    mode;
    int    exp_err;
    int    exp_fv;
    int    exp_pass;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n;
    int dones;

    tbl[0] = '{"good_h4",     0, 0, 0, 0, 1};
    tbl[1] = '{"t2_stuck0",   0, 1, 4, 0, 0};
    tbl[2] = '{"swap_h2",     1, 2, 4, 2, 0};
    tbl[3] = '{"invert_sat",  2, 3, 3, 0, 0};
    tbl[4] = '{"good_again",  0, 0, 0, 0, 1};

    for (int k = 0; k < 3; k++) begin
      rs[k] = 1'b1;
      st[k] = 1'b0;
      md[k] = 2'd0;
    end
    repeat (3) step();

    // Reset state, with start held high to show it is ignored under reset.
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    chk("rst.abc", int'({ao[0], bo[0], co[0]}), 0);
    chk("rst.busy_done_pass", int'({bz[0], dn[0], ps[0]}), 0);
    chk("rst.err_fv_vi", int'({ev[0], fv[0], vi[0]}), 0);
    for (int k = 0; k < 3; k++) rs[k] = 1'b0;
    repeat (5) step();

    for (int i = 0; i < 5; i++) begin
      md[tbl[i].inst] = 2'(tbl[i].mode);
      run_check(tbl[i].name, tbl[i].inst, tbl[i].exp_err, tbl[i].exp_fv, tbl[i].exp_pass);
      repeat (2) step();
    end

    // Reset in the middle of vector 5 aborts without a done pulse.
    md[0] = 2'd1;
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    n = 0;
    while (vi[0] != 3'd5 && n < 100) begin
      step();
      n++;
    end
    chk("abort.reach_vec5", int'(vi[0]), 5);
    rs[0] = 1'b1;
    step();
    rs[0] = 1'b0;
    chk("abort.abc_vi", int'({ao[0], bo[0], co[0], vi[0]}), 0);
    chk("abort.busy_done_pass", int'({bz[0], dn[0], ps[0]}), 0);
    chk("abort.err_fv", int'({ev[0], fv[0]}), 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (dn[0] || bz[0]) dones++;
      step();
    end
    chk("abort.no_done", dones, 0);
    md[0] = 2'd0;
    run_check("after_abort", 0, 0, 0, 1);

    // Extra starts while busy and in DONE are ignored; a start in the first
    // idle cycle afterwards begins a new run and clears the result.
    md[0] = 2'd1;
    st[0] = 1'b1;
    step();
    n = 0;
    dones = 0;
    while (!dn[0] && n < 200) begin
      st[0] = (n == 3 || n == 17 || n == 31);
      step();
      n++;
    end
    chk("restart.latency", n, 32);
    chk("restart.err_first", int'(ev[0]), 4);
    st[0] = 1'b1;                       // start during DONE
    step();
    chk("restart.done_ignored", int'({bz[0], dn[0]}), 0);
    chk("restart.pass_kept", int'(ps[0]), 0);
    md[0] = 2'd0;                       // start still high: first idle cycle
    step();
    st[0] = 1'b0;
    chk("restart.busy", int'(bz[0]), 1);
    chk("restart.cleared", int'({ev[0], fv[0], ps[0]}), 0);
    n = 0;
    while (!dn[0] && n < 200) begin
      if (dn[0]) dones++;
      step();
      n++;
    end
    chk("restart.latency2", n, 32);
    chk("restart.pass2", int'({ps[0], ev[0]}), 16);
    step();
    chk("restart.single_done", int'(dn[0]) + dones, 0);
    $display("run restart: second run cycles=%0d err=%0d pass=%0d", n, ev[0], ps[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
